// File: rtl/pipe_arith_pkg.sv
// Shared types and the pure arithmetic function used by the pipelined unit
// and by any single-cycle reference model.
package pipe_arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_XOR = 2'd3
  } op_t;

  localparam int MAX_DEPTH = 7;
  localparam int OCC_W     = 3;
  // Widest supported datapath; narrower callers zero-extend and keep the low bits,
  // which is exact for add, sub, mul-low and xor.
  localparam int CALC_W    = 64;

  function automatic logic [CALC_W-1:0] compute(op_t op, logic [CALC_W-1:0] a,
                                                logic [CALC_W-1:0] b);
    case (op)
      OP_ADD:  compute = a + b;
      OP_SUB:  compute = a - b;
      OP_MUL:  compute = a * b;
      default: compute = a ^ b;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline slot (valid + data); clear beats enable, latency 1 cycle.
// Holds its contents whenever enable is low, which is how a downstream stall is absorbed.
module pipe_stage_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         d_valid,
  input  logic [W-1:0] d_data,
  output logic         q_valid,
  output logic [W-1:0] q_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else if (clr) begin
      q_valid <= 1'b0;
    end else if (en) begin
      q_valid <= d_valid;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_arith_unit.sv
// Fixed-latency arithmetic pipeline: result appears DEPTH cycles after accept.
// A held output freezes every stage and drops in_ready; flush empties all stages.
module pipe_arith_unit
  import pipe_arith_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [OCC_W-1:0]      occupancy,
  output logic                  busy
);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("pipe_arith_unit: DEPTH must be within 1..7");
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > CALC_W) begin : g_bad_width
    $error("pipe_arith_unit: DATA_WIDTH must be within 1..64");
  end

  logic                  stall;
  logic                  accept;
  logic [CALC_W-1:0]     a_ext;
  logic [CALC_W-1:0]     b_ext;
  logic [CALC_W-1:0]     wide_res;
  logic                  unused_hi;
  logic [DEPTH:0]        v_chain;
  logic [DATA_WIDTH-1:0] d_chain [DEPTH+1];
  logic [OCC_W-1:0]      occ;
  logic                  ever_accepted;

  // All arithmetic is done ahead of stage 1; later stages only carry the value.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[DATA_WIDTH-1:0] = operand_a;
    b_ext[DATA_WIDTH-1:0] = operand_b;
    wide_res = compute(op_t'(op), a_ext, b_ext);
  end
  assign unused_hi = &{1'b0, wide_res};

  assign v_chain[0] = in_valid;
  assign d_chain[0] = wide_res[DATA_WIDTH-1:0];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_stage_reg #(.W(DATA_WIDTH)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (!stall),
      .clr     (flush),
      .d_valid (v_chain[i]),
      .d_data  (d_chain[i]),
      .q_valid (v_chain[i+1]),
      .q_data  (d_chain[i+1])
    );
  end

  assign out_valid = v_chain[DEPTH];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign accept    = in_valid && in_ready && !flush;
  assign result    = out_valid ? d_chain[DEPTH] : '0;

  always_comb begin
    occ = '0;
    for (int i = 1; i <= DEPTH; i++) begin
      occ = occ + OCC_W'(v_chain[i]);
    end
  end
  assign occupancy = occ;
  assign busy      = (occ != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ever_accepted <= 1'b0;
    end else if (accept) begin
      ever_accepted <= 1'b1;
    end
  end

  a_result_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (stall && !flush) |=> $stable(result));
  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= OCC_W'(DEPTH));
  a_no_phantom: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> ever_accepted);

endmodule

// File: tb/tb_pipe_arith_unit.sv
// Scoreboard bench: a DEPTH=3 and a DEPTH=1 unit share one stimulus stream,
// each with its own expected-result queue checked by an independent monitor.
module tb_pipe_arith_unit;

  localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, MUL = 2'd2, XOR = 2'd3;

  typedef struct {
    logic [31:0] res;
    int          acc_edge;
    int          acc_stall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        out_ready;

  logic        in_ready_w  [2];
  logic        out_valid_w [2];
  logic [31:0] result_w    [2];
  logic [2:0]  occ_w       [2];
  logic        busy_w      [2];

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  pipe_arith_unit #(.DATA_WIDTH(32), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .op(op), .operand_a(a), .operand_b(b), .flush(flush),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .result(result_w[0]),
    .occupancy(occ_w[0]), .busy(busy_w[0])
  );

  pipe_arith_unit #(.DATA_WIDTH(32), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .op(op), .operand_a(a), .operand_b(b), .flush(flush),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .result(result_w[1]),
    .occupancy(occ_w[1]), .busy(busy_w[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: full-precision result, truncated to 32 bits.
  function automatic logic [31:0] ref_op(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    logic [63:0] p;
    p = {32'd0, x} * {32'd0, y};
    case (o)
      ADD:     return x + y;
      SUB:     return x - y;
      MUL:     return p[31:0];
      default: return x ^ y;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int D = (g == 0) ? 3 : 1;
    exp_t        q[$];
    int          stall_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res = '0;

    // Samples at the falling edge what the next rising edge will do.
    initial begin
      forever begin
        exp_t e;
        logic stl;
        @(negedge clk);
        if (!rst_n) begin
          q.delete();
          prev_stall = 1'b0;
          chk($sformatf("d%0d reset out_valid", D), 32'(out_valid_w[g]), 32'd0);
          chk($sformatf("d%0d reset result", D), result_w[g], 32'd0);
          chk($sformatf("d%0d reset occupancy", D), 32'(occ_w[g]), 32'd0);
          chk($sformatf("d%0d reset in_ready", D), 32'(in_ready_w[g]), 32'd1);
        end else begin
          stl = out_valid_w[g] && !out_ready;
          chk($sformatf("d%0d in_ready", D), 32'(in_ready_w[g]), 32'(!stl));
          chk($sformatf("d%0d occupancy", D), 32'(occ_w[g]), 32'(q.size()));
          chk($sformatf("d%0d busy", D), 32'(busy_w[g]), 32'(q.size() != 0));
          if (!out_valid_w[g]) chk($sformatf("d%0d idle result", D), result_w[g], 32'd0);
          if (prev_stall) chk($sformatf("d%0d stalled result", D), result_w[g], prev_res);
          if (out_valid_w[g] && out_ready) begin
            if (q.size() == 0) begin
              chk($sformatf("d%0d unexpected output", D), 32'd1, 32'd0);
            end else begin
              e = q.pop_front();
              chk($sformatf("d%0d result", D), result_w[g], e.res);
              chk($sformatf("d%0d latency", D),
                  32'((edge_cnt + 1) - e.acc_edge - (stall_cnt - e.acc_stall)), 32'(D));
            end
          end
          if (flush) begin
            q.delete();
          end else if (in_valid && in_ready_w[g]) begin
            e.res = ref_op(op, a, b);
            e.acc_edge = edge_cnt + 1;
            e.acc_stall = stall_cnt;
            q.push_back(e);
          end
          if (stl && !flush) stall_cnt++;
          prev_stall = stl && !flush;
          prev_res = result_w[g];
        end
      end
    end
  end

  task automatic offer(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y;
  endtask

  task automatic idle_after_edge();
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    op = ADD; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy_w[0]), 32'd0);
    chk("reset in_ready", 32'(in_ready_w[0]), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // Single add: occupancy 1,1,1 then 0, output on the third cycle.
    offer(ADD, 32'h5, 32'h7);
    idle_after_edge();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("single occupancy", 32'(occ_w[0]), (i < 3) ? 32'd1 : 32'd0);
      chk("single out_valid", 32'(out_valid_w[0]), (i == 2) ? 32'd1 : 32'd0);
      if (i == 2) chk("single result", result_w[0], 32'h0000_000C);
    end

    // Back-to-back throughput.
    offer(MUL, 32'hFFFF_FFFF, 32'h2);
    offer(SUB, 32'h3, 32'h5);
    offer(XOR, 32'hF0F0_F0F0, 32'hFFFF_0000);
    idle_after_edge();
    @(negedge clk);
    chk("b2b peak occupancy", 32'(occ_w[0]), 32'd3);
    chk("b2b result0", result_w[0], 32'hFFFF_FFFE);
    @(negedge clk);
    chk("b2b result1", result_w[0], 32'hFFFF_FFFE);
    @(negedge clk);
    chk("b2b result2", result_w[0], 32'h0F0F_F0F0);
    @(negedge clk);
    chk("b2b drained", 32'(occ_w[0]), 32'd0);

    // Backpressure with 0xAA held at the output and a fourth op waiting.
    offer(ADD, 32'hA0, 32'h0A);
    offer(ADD, 32'h1, 32'h2);
    offer(XOR, 32'h10, 32'h01);
    @(posedge clk); #1;
    out_ready = 1'b0; op = ADD; a = 32'h4; b = 32'h4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp result held", result_w[0], 32'h0000_00AA);
      chk("bp in_ready low", 32'(in_ready_w[0]), 32'd0);
      chk("bp occupancy", 32'(occ_w[0]), 32'd3);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle_after_edge();
    @(negedge clk); chk("bp order0", result_w[0], 32'h3);
    @(negedge clk); chk("bp order1", result_w[0], 32'h11);
    @(negedge clk); chk("bp order2", result_w[0], 32'h8);
    @(negedge clk); chk("bp drained", 32'(occ_w[0]), 32'd0);

    // Flush with three ops in flight and a fourth offered.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; op = ADD; a = 32'h11; b = 32'h22;
    offer(SUB, 32'h33, 32'h1);
    offer(MUL, 32'h7, 32'h6);
    @(posedge clk); #1;
    op = XOR; a = 32'h55; b = 32'hAA; flush = 1'b1;
    @(negedge clk);
    chk("flush pre occupancy", 32'(occ_w[0]), 32'd3);
    idle_after_edge();
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush occupancy", 32'(occ_w[0]), 32'd0);
    chk("flush out_valid", 32'(out_valid_w[0]), 32'd0);
    chk("flush busy", 32'(busy_w[0]), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("flush no output", 32'(out_valid_w[0]), 32'd0);
    end

    // Flush while ready: the offered op is still dropped.
    offer(ADD, 32'h9, 32'h9);
    @(posedge clk); #1;
    a = 32'h2; b = 32'h2; flush = 1'b1;
    @(negedge clk);
    chk("flush in_ready", 32'(in_ready_w[0]), 32'd1);
    idle_after_edge();
    @(negedge clk);
    chk("flush2 occupancy", 32'(occ_w[0]), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("flush2 no output", 32'(out_valid_w[0]), 32'd0);
    end

    // Asynchronous reset in the middle of a full stall.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; op = ADD; a = 32'h100; b = 32'h1;
    offer(SUB, 32'h200, 32'h1);
    offer(MUL, 32'h300, 32'h3);
    idle_after_edge();
    @(negedge clk);
    chk("pre-reset occupancy", 32'(occ_w[0]), 32'd3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(out_valid_w[0]), 32'd0);
    chk("async rst result", result_w[0], 32'd0);
    chk("async rst occupancy", 32'(occ_w[0]), 32'd0);
    chk("async rst busy", 32'(busy_w[0]), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1; out_ready = 1'b1;
    offer(ADD, 32'h1, 32'h1);
    idle_after_edge();
    @(negedge clk); chk("post-reset wait0", 32'(out_valid_w[0]), 32'd0);
    @(negedge clk); chk("post-reset wait1", 32'(out_valid_w[0]), 32'd0);
    @(negedge clk);
    chk("post-reset out_valid", 32'(out_valid_w[0]), 32'd1);
    chk("post-reset result", result_w[0], 32'h0000_0002);

    // Random traffic with random backpressure and occasional flushes.
    repeat (400) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 1) == 1);
      op        = 2'($urandom_range(0, 3));
      a         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      b         = $urandom;
      out_ready = ($urandom_range(0, 4) > 1);
      flush     = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (g_mon[0].q.size() == 0 && g_mon[1].q.size() == 0) break;
    end
    chk("drain d3 pending", 32'(g_mon[0].q.size()), 32'd0);
    chk("drain d1 pending", 32'(g_mon[1].q.size()), 32'd0);
    chk("drain d3 busy", 32'(busy_w[0]), 32'd0);
    chk("drain d1 busy", 32'(busy_w[1]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
